serial_add_ctrl: RTL and testbench

//   Bit-serial add/subtract controller. Sequences one 1-bit structural full-adder

---
 rtl/serial_add_ctrl.sv | 133 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one full-adder cell is stepped LSB first
// over WIDTH-bit operands, one bit per clock, with a start/done handshake.

// Single-bit structural full-adder cell reused on every bit time.
module serial_add_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic ab_x;
    logic ab_a;
    logic xc_a;

    assign ab_x = a ^ b;
    assign ab_a = a & b;
    assign xc_a = ab_x & ci;
    assign s    = ab_x ^ ci;
    assign co   = ab_a | xc_a;
endmodule

// Handshake: start is a single-cycle request sampled only in IDLE; there is no
// back-pressure. Requests arriving in RUN or DONE are dropped, not queued.
// done pulses for one cycle and marks sum_out, c_out and overflow valid; those
// results then hold until the next operation completes or reset clears them.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out,
    output logic             overflow,
    output logic [1:0]       state_dbg
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [CW-1:0]    cnt;
    logic             carry;

    logic             fa_s;
    logic             fa_co;
    logic             c_msb_in;
    logic             last_bit;
    logic [WIDTH-1:0] res_next;

    serial_add_fa u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // On the final bit the live carry is the carry into the MSB.
    assign c_msb_in  = carry;
    assign last_bit  = (cnt == LAST_BIT);
    assign res_next  = {fa_s, res_sh[WIDTH-1:1]};
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum_out  <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert B, seed carry with 1.
                        a_sh  <= a_in;
                        b_sh  <= sub ? ~b_in : b_in;
                        carry <= sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res_sh <= res_next;
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    carry  <= fa_co;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        sum_out  <= res_next;
                        c_out    <= fa_co;
                        overflow <= c_msb_in ^ fa_co;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: cycle-level reference model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_serial_add_ctrl;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             sub = 1'b0;
    logic [WIDTH-1:0] a_in = '0;
    logic [WIDTH-1:0] b_in = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             c_out;
    logic             overflow;
    logic [1:0]       state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sub       (sub),
        .a_in      (a_in),
        .b_in      (b_in),
        .busy      (busy),
        .done      (done),
        .sum_out   (sum_out),
        .c_out     (c_out),
        .overflow  (overflow),
        .state_dbg (state_dbg)
    );

    // Clock: posedges at 5, 15, 25 ...; inputs change and outputs are read on negedges.
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result from signed/unsigned integer arithmetic.
    function automatic logic [WIDTH+1:0] ref_calc(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic s);
        int ua;
        int ub;
        int sa;
        int sb;
        int ures;
        int sres;
        logic [WIDTH-1:0] r;
        logic c;
        logic ov;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (s) begin
            ures = ua - ub;
            sres = sa - sb;
            c = (ua >= ub);
        end else begin
            ures = ua + ub;
            sres = sa + sb;
            c = (ures >= (1 << WIDTH));
        end
        r  = ures[WIDTH-1:0];
        ov = (sres > (1 << (WIDTH - 1)) - 1) || (sres < -(1 << (WIDTH - 1)));
        return {ov, c, r};
    endfunction

    // Cycle-level model: accept when idle, results appear WIDTH edges later.
    logic             m_busy;
    logic             m_done;
    logic [WIDTH-1:0] m_sum;
    logic             m_c;
    logic             m_ov;
    logic [WIDTH+1:0] m_pend;
    int               m_left;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_sum  <= '0;
            m_c    <= 1'b0;
            m_ov   <= 1'b0;
            m_pend <= '0;
            m_left <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
            m_busy <= 1'b0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_sum  <= m_pend[WIDTH-1:0];
                m_c    <= m_pend[WIDTH];
                m_ov   <= m_pend[WIDTH+1];
            end
        end else if (start) begin
            m_pend <= ref_calc(a_in, b_in, sub);
            m_busy <= 1'b1;
            m_left <= WIDTH;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("sum_out", 32'(sum_out), 32'(m_sum));
            chk("c_out", 32'(c_out), 32'(m_c));
            chk("overflow", 32'(overflow), 32'(m_ov));
        end
    end

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4 * WIDTH; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        @(negedge clk);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        sub   = s;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic s,
                          input logic [WIDTH-1:0] e_sum, input logic e_c, input logic e_ov);
        issue(a, b, s);
        wait_done(name);
        chk({name, "_sum"}, 32'(sum_out), 32'(e_sum));
        chk({name, "_c"}, 32'(c_out), 32'(e_c));
        chk({name, "_ov"}, 32'(overflow), 32'(e_ov));
        @(negedge clk);
        chk({name, "_done_width"}, 32'(done), 32'd0);
    endtask

    int done_at[$];
    logic [WIDTH-1:0] done_sum[$];
    int dones_seen;

    initial begin
        // Reset state.
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum_out), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);
        #2 rst = 1'b0;
        check_en = 1'b1;

        // T1..T3 directed vectors.
        run_op("t1", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        run_op("t2", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("t3a", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
        run_op("t3b", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        run_op("t3c", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("t3d", 8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0);

        // T4: start held 20 cycles, operands disturbed while busy.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                done_at.push_back(i);
                done_sum.push_back(sum_out);
            end
            start = 1'b1;
            sub   = (i >= 2 && i <= 7);
            a_in  = (i >= 2 && i <= 7) ? 8'hC3 : 8'h01;
            b_in  = (i >= 2 && i <= 7) ? 8'h7E : 8'h02;
        end
        @(negedge clk);
        start = 1'b0;
        chk("t4_ops", 32'(done_at.size()), 32'd2);
        if (done_at.size() == 2) begin
            chk("t4_gap", 32'(done_at[1] - done_at[0]), 32'd10);
            chk("t4_sum0", 32'(done_sum[0]), 32'h03);
            chk("t4_sum1", 32'(done_sum[1]), 32'h03);
        end
        repeat (3) @(negedge clk);
        chk("t4_idle", 32'(busy), 32'd0);

        // T5: reset during the fourth RUN cycle aborts the operation.
        issue(8'h33, 8'h44, 1'b0);
        repeat (3) @(negedge clk);
        chk("t5_busy_before", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_sum", 32'(sum_out), 32'd0);
        chk("t5_state", 32'(state_dbg), 32'd0);
        dones_seen = 0;
        for (int i = 0; i < 3 * WIDTH; i++) begin
            @(negedge clk);
            if (done) dones_seen++;
        end
        chk("t5_no_done", 32'(dones_seen), 32'd0);
        run_op("t5_next", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);

        // T6: random operations against the model.
        for (int n = 0; n < 1000; n++) begin
            issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)));
            wait_done("t6");
            @(negedge clk);
        end

        @(negedge clk);
        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
